// File: rtl/aes_256_sched_if.sv
// Requester, core and response signals of the shared AES-256 scheduler.
// The slave modport is the scheduler; master is the fabric/core side.
interface aes_256_sched_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 32
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_state;
  logic [NUM_REQ*256-1:0] req_key;
  logic [127:0]           core_state;
  logic [255:0]           core_key;
  logic [127:0]           core_out;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [127:0]           rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic [CNT_W-1:0]       inflight;

  modport slave (
    input  req_valid, req_state, req_key, core_out, rsp_ready,
    output req_ready, core_state, core_key, rsp_valid, rsp_data, rsp_id, inflight
  );

  modport master (
    output req_valid, req_state, req_key, core_out, rsp_ready,
    input  req_ready, core_state, core_key, rsp_valid, rsp_data, rsp_id, inflight
  );
endinterface

// File: rtl/aes_256_sched.sv
// Round-robin front end for one stall-free AES-256 pipeline: issues requests,
// tracks them with a valid/id token pipe and collects results in a credit-bounded FIFO.
module aes_256_sched #(
  parameter int NUM_REQ    = 4,
  parameter int CORE_LAT   = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  aes_256_sched_if.slave  io_bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  logic [ID_W-1:0]    r_rr;
  logic [ID_W-1:0]    w_gid;
  logic               w_accept;
  logic               w_credit_ok;
  logic [NUM_REQ-1:0] w_grant;

  logic [127:0] w_state_s [NUM_REQ];
  logic [255:0] w_key_s   [NUM_REQ];

  logic [127:0] r_core_state;
  logic [255:0] r_core_key;

  logic [CORE_LAT:0] r_vp_valid;
  logic [ID_W-1:0]   r_vp_id [CORE_LAT+1];

  logic [ID_W+127:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              w_empty;
  logic              w_full;
  logic              w_capture;
  logic              w_pop;
  logic [CNT_W-1:0]  r_inflight;

  function automatic logic [ID_W-1:0] f_wrap(input int v);
    int s;
    s = v;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_state_s[gi] = io_bus.req_state[128*gi +: 128];
    assign w_key_s[gi]   = io_bus.req_key[256*gi +: 256];
  end

  assign w_credit_ok = (r_inflight < CNT_W'(FIFO_DEPTH));

  // Scan from the farthest offset down so the requester nearest rr wins last.
  always_comb begin
    w_gid    = '0;
    w_accept = 1'b0;
    if (i_rst_n && w_credit_ok) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (io_bus.req_valid[f_wrap(int'(r_rr) + k)]) begin
          w_accept = 1'b1;
          w_gid    = f_wrap(int'(r_rr) + k);
        end
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_accept) w_grant[w_gid] = 1'b1;
  end

  assign io_bus.req_ready = w_grant;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr         <= '0;
      r_core_state <= '0;
      r_core_key   <= '0;
    end else begin
      r_core_state <= w_accept ? w_state_s[w_gid] : '0;
      r_core_key   <= w_accept ? w_key_s[w_gid]   : '0;
      if (w_accept) r_rr <= f_wrap(int'(w_gid) + 1);
    end
  end

  // Stage 0 rides with the core input register; stage k lines up with core stage k.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vp_valid <= '0;
      for (int k = 0; k <= CORE_LAT; k++) r_vp_id[k] <= '0;
    end else begin
      r_vp_valid <= {r_vp_valid[CORE_LAT-1:0], w_accept};
      r_vp_id[0] <= w_accept ? w_gid : '0;
      for (int k = 1; k <= CORE_LAT; k++) r_vp_id[k] <= r_vp_id[k-1];
    end
  end

  assign w_capture = r_vp_valid[CORE_LAT];
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = !w_empty && io_bus.rsp_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_capture) r_mem[r_wptr[AW-1:0]] <= {r_vp_id[CORE_LAT], io_bus.core_out};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= '0;
    end else begin
      if (w_capture) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)     r_rptr <= r_rptr + (AW+1)'(1);
      case ({w_accept, w_pop})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Credit accounting must make a capture into a full FIFO impossible.
  assert property (@(posedge i_clk) disable iff (!i_rst_n) w_capture |-> !w_full);

  assign io_bus.core_state = r_core_state;
  assign io_bus.core_key   = r_core_key;
  assign io_bus.rsp_valid  = !w_empty;
  assign {io_bus.rsp_id, io_bus.rsp_data} = r_mem[r_rptr[AW-1:0]];
  assign io_bus.inflight   = r_inflight;
endmodule

// File: tb/tb_aes_256_sched.sv
// Bench for aes_256_sched: AES-256 stub core, queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_aes_256_sched;
  localparam int NUM_REQ    = 4;
  localparam int CORE_LAT   = 16;
  localparam int FIFO_DEPTH = 32;
  localparam int ID_W       = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_256_sched_if #(.NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  aes_256_sched #(.NUM_REQ(NUM_REQ), .CORE_LAT(CORE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  logic [7:0] sbox [256];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic sbox_init();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
  endfunction

  function automatic logic [127:0] aes256(input logic [127:0] pt, input logic [255:0] key);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xtime(rc);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int r = 0; r <= 14; r++) begin
      if (r > 0) begin
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 4; j++) t[j+4*c] = sbox[s[j+4*((c+j)%4)]];
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          if (r < 14) begin
            s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
          end else begin
            s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) s[4*c+j] = s[4*c+j] ^ w[4*r+c][31-8*j -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Stub core: true AES of the registered inputs, delayed CORE_LAT cycles.
  logic [127:0] stub [CORE_LAT];
  always @(posedge clk) begin
    stub[0] <= aes256(bus.core_state, bus.core_key);
    for (int k = 1; k < CORE_LAT; k++) stub[k] <= stub[k-1];
  end
  assign bus.core_out = stub[CORE_LAT-1];

  typedef struct {
    logic [ID_W-1:0] id;
    logic [127:0]    data;
    int              rdy;
  } exp_t;

  exp_t         exp_q [$];
  int           grant_log [$];
  int           m_rr, m_inflight, cyc, dut_acc;
  logic [127:0] m_cs;
  logic [255:0] m_ck;
  int           pend [NUM_REQ];
  logic [127:0] st_d [NUM_REQ];
  logic [255:0] key_d [NUM_REQ];
  int           rdy_mode;
  bit           jitter;
  int           checks, failures;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i] = (pend[i] > 0) && (!jitter || $urandom_range(3) != 0);
      bus.req_state[128*i +: 128] = st_d[i];
      bus.req_key[256*i +: 256]   = key_d[i];
    end
    case (rdy_mode)
      0:       bus.rsp_ready = 1'b0;
      1:       bus.rsp_ready = 1'b1;
      default: bus.rsp_ready = 1'($urandom_range(1));
    endcase
  endtask

  // Expected grant: the valid requester at the smallest round-robin distance from rr.
  function automatic int exp_grant();
    if (!rst_n || m_inflight >= FIFO_DEPTH) return -1;
    for (int d = 0; d < NUM_REQ; d++)
      if (bus.req_valid[(m_rr + d) % NUM_REQ]) return (m_rr + d) % NUM_REQ;
    return -1;
  endfunction

  task automatic tick();
    int                 g;
    logic [NUM_REQ-1:0] eg;
    bit                 exp_v, pop;
    exp_t               e;
    @(negedge clk);
    g  = exp_grant();
    eg = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    if (|(bus.req_valid & bus.req_ready)) dut_acc++;
    chk("req_ready", bus.req_ready, eg);
    chk("inflight", bus.inflight, m_inflight);
    chk("core_state", bus.core_state, m_cs);
    chk("core_key", bus.core_key, m_ck);
    exp_v = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
    chk("rsp_valid", bus.rsp_valid, exp_v);
    pop = rst_n && exp_v && bus.rsp_ready;
    if (pop) begin
      e = exp_q.pop_front();
      chk("rsp_id", bus.rsp_id, e.id);
      chk("rsp_data", bus.rsp_data, e.data);
    end
    m_cs = '0;
    m_ck = '0;
    if (g >= 0) begin
      exp_q.push_back('{id: ID_W'(g), data: aes256(st_d[g], key_d[g]), rdy: cyc + CORE_LAT + 2});
      grant_log.push_back(g);
      m_rr = (g + 1) % NUM_REQ;
      m_cs = st_d[g];
      m_ck = key_d[g];
    end
    m_inflight = m_inflight + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
    if (!rst_n) begin
      exp_q.delete();
      m_inflight = 0;
      m_rr = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (g >= 0) begin
      pend[g]--;
      st_d[g]  = {$urandom, $urandom, $urandom, $urandom};
      key_d[g] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    drive_reqs();
  endtask

  function automatic bit busy();
    bit b = exp_q.size() > 0;
    for (int i = 0; i < NUM_REQ; i++) if (pend[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_drain(input int lim, input string tag);
    int n = 0;
    while (busy() && n < lim) begin
      tick();
      n++;
    end
    chk(tag, busy(), 1'b0);
  endtask

  task automatic set_pend(input int v);
    for (int i = 0; i < NUM_REQ; i++) pend[i] = v;
  endtask

  initial begin
    int lat, n, acc0;
    sbox_init();
    checks = 0; failures = 0; cyc = 0; dut_acc = 0;
    m_rr = 0; m_inflight = 0; m_cs = '0; m_ck = '0;
    rdy_mode = 1; jitter = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i]  = 0;
      st_d[i]  = {$urandom, $urandom, $urandom, $urandom};
      key_d[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    drive_reqs();

    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_inflight", bus.inflight, 0);
    chk("reset_core_state", bus.core_state, 0);

    // Known-answer request from requester 2.
    st_d[2]  = 128'h00112233445566778899aabbccddeeff;
    key_d[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    pend[2]  = 1;
    drive_reqs();
    lat = -1;
    for (int k = 0; k < CORE_LAT + 10 && lat < 0; k++) begin
      tick();
      if (bus.rsp_valid) begin
        lat = k;
        chk("kat_data", bus.rsp_data, 128'h8ea2b7ca516745bfeafc49904b496089);
        chk("kat_id", bus.rsp_id, 2);
      end
    end
    chk("kat_latency", lat, CORE_LAT + 1);
    run_drain(50, "kat_drain");

    // All four held from a fresh reset: strict rotation.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    grant_log.delete();
    set_pend(2);
    drive_reqs();
    n = 0;
    while (grant_log.size() < 8 && n < 50) begin tick(); n++; end
    chk("rr_accepts", grant_log.size(), 8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) chk("rr_order", grant_log[k], k % NUM_REQ);
    run_drain(100, "rr_drain");

    // After a grant to 1, only 0 and 3 compete: 3 first, then 0.
    grant_log.delete();
    pend[1] = 1;
    drive_reqs();
    n = 0;
    while (grant_log.size() < 1 && n < 20) begin tick(); n++; end
    pend[0] = 1;
    pend[3] = 1;
    drive_reqs();
    n = 0;
    while (grant_log.size() < 3 && n < 20) begin tick(); n++; end
    chk("skip_first", (grant_log.size() > 1) ? grant_log[1] : -1, 3);
    chk("skip_second", (grant_log.size() > 2) ? grant_log[2] : -1, 0);
    run_drain(100, "skip_drain");

    // Backpressure: exactly FIFO_DEPTH credits.
    rdy_mode = 0;
    set_pend(1000);
    drive_reqs();
    acc0 = dut_acc;
    repeat (80) tick();
    chk("bp_accepts", dut_acc - acc0, FIFO_DEPTH);
    chk("bp_ready", bus.req_ready, 0);
    chk("bp_inflight", bus.inflight, FIFO_DEPTH);

    // One pop at depth frees exactly one credit.
    acc0 = dut_acc;
    rdy_mode = 1;
    bus.rsp_ready = 1'b1;
    tick();
    rdy_mode = 0;
    bus.rsp_ready = 1'b0;
    repeat (3) tick();
    chk("pop_one_accept", dut_acc - acc0, 1);
    chk("pop_inflight", bus.inflight, FIFO_DEPTH);
    rdy_mode = 1;
    repeat (60) tick();
    set_pend(0);
    run_drain(200, "bp_drain");
    chk("bp_drained", bus.inflight, 0);

    // Mid-flight reset discards ten tokens.
    set_pend(1000);
    drive_reqs();
    acc0 = dut_acc;
    n = 0;
    while (dut_acc - acc0 < 10 && n < 30) begin tick(); n++; end
    set_pend(0);
    rst_n = 1'b0;
    drive_reqs();
    tick();
    rst_n = 1'b1;
    chk("flush_rsp_valid", bus.rsp_valid, 1'b0);
    chk("flush_inflight", bus.inflight, 0);
    repeat (CORE_LAT + 6) tick();
    chk("flush_quiet", bus.rsp_valid, 1'b0);
    pend[1] = 1;
    drive_reqs();
    run_drain(60, "flush_new_req");

    // Randomized traffic with valid jitter and random backpressure.
    jitter = 1'b1;
    rdy_mode = 2;
    for (int i = 0; i < NUM_REQ; i++) pend[i] = $urandom_range(30, 10);
    drive_reqs();
    run_drain(3000, "rand_drain");
    chk("rand_inflight", bus.inflight, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
